// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM state encoding and FP16 constants for the PE operand feeder
package pe_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE, DONE} feeder_state_t;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
endpackage

// File: rtl/pe_addr_gen.sv
// pe_addr_gen: latched base plus wrapping element index, with last/empty flags
// ports: load latches base/len and clears the index; en advances the index;
//        addr = base + index (wraps); last = index is len-1; empty = len is 0
module pe_addr_gen
  import pe_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic                  empty
);
  logic [ADDR_WIDTH-1:0] origin;
  logic [LEN_WIDTH-1:0] count, idx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      origin <= '0;
      count  <= '0;
      idx    <= '0;
    end else if (load) begin
      origin <= base;
      count  <= len;
      idx    <= '0;
    end else if (en) idx <= idx + LEN_WIDTH'(1);
  assign addr  = origin + ADDR_WIDTH'(idx);
  assign last  = idx == count - LEN_WIDTH'(1);
  assign empty = count == '0;
endmodule

// File: rtl/pe_dot_feeder.sv
// pe_dot_feeder: streams two FP16 vectors into the MAC PE and hands the dot product downstream
// ports: start/vec_len/base_a/base_b command; rd_* operand memory read port (1-cycle latency);
//        acc_clr/pe_a/pe_b/pe_result PE side; result/out_valid/out_ready downstream handshake
module pe_dot_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  acc_clr,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  out_valid,
  input  logic                  out_ready
);
  feeder_state_t state, next;
  logic load, data_vld, last_a, last_b, empty_a, empty_b;
  assign load = state == IDLE && start;
  pe_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) gen_a (
    .clk, .rstn, .load, .en(rd_en), .base(base_a), .len(vec_len),
    .addr(rd_addr_a), .last(last_a), .empty(empty_a)
  );
  pe_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) gen_b (
    .clk, .rstn, .load, .en(rd_en), .base(base_b), .len(vec_len),
    .addr(rd_addr_b), .last(last_b), .empty(empty_b)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CLEAR : IDLE;
      CLEAR:   next = (empty_a && empty_b) ? DRAIN : FETCH;
      FETCH:   next = (last_a && last_b) ? DRAIN : FETCH;
      DRAIN:   next = CAPTURE;
      CAPTURE: next = DONE;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    acc_clr   = state == CLEAR;
    rd_en     = state == FETCH;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      data_vld <= 1'b0;
      result   <= DATA_WIDTH'(FP16_ZERO);
    end else begin
      data_vld <= rd_en;
      if (state == CAPTURE) result <= pe_result;
    end
  // +0 operands outside the data window keep the PE accumulator frozen
  assign pe_a = data_vld ? rd_data_a : DATA_WIDTH'(FP16_ZERO);
  assign pe_b = data_vld ? rd_data_b : DATA_WIDTH'(FP16_ZERO);
endmodule

// File: doc/pe_dot_feeder.md
# pe_dot_feeder

Sequencer at the operand side of the FP16 multiply-accumulate processing element. On a start command it clears the accumulator, streams two FP16 vectors from two read-only operand memories into the PE's `floatA`/`floatB` inputs, waits for the last product to be accumulated, captures the PE result and offers it downstream on a valid/ready handshake. It is the PE's only source of operands and the only consumer of its result.

## Interface
- `DATA_WIDTH`, 16: FP16 operand and result width.
- `ADDR_WIDTH`, 10: operand-memory address width.
- `LEN_WIDTH`, 10: vector-length field width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `vec_len`  in  LEN_WIDTH  element count, latched with `start`.
- `base_a`, `base_b`  in  ADDR_WIDTH  start addresses, latched with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `rd_en`  out  1  operand-memory read strobe.
- `rd_addr_a`, `rd_addr_b`  out  ADDR_WIDTH  read addresses.
- `rd_data_a`, `rd_data_b`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `rd_en`.
- `acc_clr`  out  1  synchronous accumulator clear to the PE.
- `pe_a`, `pe_b`  out  DATA_WIDTH  PE operands.
- `pe_result`  in  DATA_WIDTH  PE accumulator, updated every clock edge.
- `result`  out  DATA_WIDTH  captured dot product.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  downstream accepts `result`.

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, CAPTURE, DONE.
- IDLE → CLEAR when `start`=1. The block latches `vec_len`, `base_a` and `base_b`, and resets the element index to 0.
- CLEAR: one cycle with `acc_clr`=1. Next state is FETCH if the latched length ≠ 0, otherwise DRAIN.
- FETCH: `rd_en`=1 and `rd_addr_x` = `base_x` + index. The sum wraps modulo 2^ADDR_WIDTH. Index increments every cycle. On the cycle where index = len−1, next state is DRAIN.
- DRAIN: one cycle, so the last returning data reaches the PE.
- CAPTURE: one cycle. `result` ← `pe_result` at the closing edge. Next state is DONE.
- DONE: `out_valid`=1 and `result` is held stable. On `out_valid` && `out_ready` → IDLE.
- `pe_a`/`pe_b` = `rd_data_a`/`rd_data_b` when `rd_en` was high in the previous cycle (registered flag `data_vld`). Otherwise both are 0x0000. A product of +0 keeps the accumulator unchanged while the block is idle.
- `start` while `busy`=1 is ignored, including `start` in the same cycle as the DONE handshake.
- The block does no arithmetic on data. Index and address arithmetic is unsigned and wraps.

## Timing
- Reset values: state IDLE, `busy`=0, `rd_en`=0, `acc_clr`=0, `out_valid`=0, `result`=0x0000, addresses 0, `data_vld`=0, hence `pe_a`=`pe_b`=0x0000.
- Cycle 0 is the `start` cycle, L = `vec_len`:
  - CLEAR in cycle 1.
  - FETCH in cycles 2..L+1.
  - Operands at the PE in cycles 3..L+2.
  - DRAIN in cycle L+2.
  - CAPTURE in cycle L+3.
  - `out_valid` from cycle L+4 onward.
- Latency from `start` to `out_valid` is L+4 cycles. For L = 0 it is 4 cycles, with `result`=0x0000.
- `busy` falls in the cycle after the handshake. The next `start` is accepted in that cycle at the earliest.
- `out_ready` held low keeps DONE indefinitely. The PE holds its value because the operands are zero.
- Reset mid-operation: asynchronous return to reset values. The PE is reset by the same `rstn`. A partial result is never presented.

## Structure
- Shared package `pe_pkg`:
  - state enum `feeder_state_t`.
  - `FP16_ZERO` = 16'h0000.
  - `FP16_ONE` = 16'h3C00 (bench use).
- One sub-module, `pe_addr_gen`. It latches the base, runs the wrapping index counter and raises a last-element flag. Two instances, one for A and one for B, share the index enable.
- The FSM, the `data_vld` pipeline flag, the operand gating and the result register live in the top module.

## Test plan
- A=[0x3C00, 0x4000, 0x4200], B=[0x3C00 ×3], `out_ready`=1, `start` at cycle 0 → `rd_addr` runs 0,1,2 in cycles 2–4; `out_valid` in cycle 7; `result`=0x4600 (6.0).
- `vec_len`=0 → `acc_clr` pulses in cycle 1; `rd_en` never asserts; `out_valid` in cycle 4 with `result`=0x0000.
- `base_a`=1022, L=4 → `rd_addr_a` reads 1022, 1023, 0, 1.
- `out_ready` held low for 10 cycles after `out_valid`, with `start` pulsed during that time → `result` stable; `start` ignored; `pe_a`=`pe_b`=0x0000; after `out_ready`=1, `busy` falls next cycle.
- Back-to-back: a second `start` in the cycle after the handshake → accepted; `acc_clr` pulses; the new result is not contaminated by the previous sum.
- `rstn` low during FETCH → all outputs at reset values immediately; no `out_valid`; a subsequent run is correct.
